// File: rtl/rca_pipe_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : rca_pipe_pkg
// Brief  : Shared constants and elaboration helpers for the pipelined RCA.
// Rev    : 1.0  initial release
// ============================================================================
package rca_pipe_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int slice_w(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 1;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (width >= 2) && ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca_slice.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : rca_slice
// Brief  : Combinational W-bit ripple-carry adder slice.
// Rev    : 1.0  initial release
// ============================================================================
module rca_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic carry;

  always_comb begin
    s     = '0;
    carry = ci;
    for (int i = 0; i < W; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    co = carry;
  end

endmodule
`default_nettype wire

// File: rtl/rca_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : rca_pipe
// Brief  : WIDTH-bit add/sub split into STAGES registered ripple slices with
//          valid/ready backpressure. Define RCA_PIPE_OVF_EN for the ovf port.
// Rev    : 1.0  initial release
// ============================================================================
module rca_pipe
  import rca_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int W    = slice_w(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  logic             adv;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;

  assign b_cap = (sub == MODE_SUB) ? ~b : b;
  assign c_cap = (sub == MODE_ADD) ? cin : 1'b1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("rca_pipe: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Stage k finishes bits [k*W +: W]; only the not-yet-added operand bits travel on.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * W;
    localparam int INW  = WIDTH - k * W;

    logic [INW-1:0]  ua;
    logic [INW-1:0]  ub;
    logic            ci;
    logic            vld_in;
    logic            co;
    logic [W-1:0]    s;
    logic [DONE-1:0] res_d;
    logic [DONE-1:0] res_q;
    logic            cy_q;
    logic            vld_q;

    if (k == 0) begin : g_head
      assign ua     = a;
      assign ub     = b_cap;
      assign ci     = c_cap;
      assign vld_in = in_valid;
      assign res_d  = s;
    end else begin : g_tail
      assign ua     = g_stage[k-1].g_ops.opa_q;
      assign ub     = g_stage[k-1].g_ops.opb_q;
      assign ci     = g_stage[k-1].cy_q;
      assign vld_in = g_stage[k-1].vld_q;
      assign res_d  = {s, g_stage[k-1].res_q};
    end

    rca_slice #(.W(W)) u_slice (
      .a  (ua[W-1:0]),
      .b  (ub[W-1:0]),
      .ci (ci),
      .s  (s),
      .co (co)
    );

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        res_q <= '0;
        cy_q  <= 1'b0;
        vld_q <= 1'b0;
      end else if (adv) begin
        res_q <= res_d;
        cy_q  <= co;
        vld_q <= vld_in;
      end
    end

    if (k < LAST) begin : g_ops
      logic [INW-W-1:0] opa_q;
      logic [INW-W-1:0] opb_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (adv) begin
          opa_q <= ua[INW-1:W];
          opb_q <= ub[INW-1:W];
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].vld_q;
  assign sum       = {g_stage[LAST].cy_q, g_stage[LAST].res_q};
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

`ifdef RCA_PIPE_OVF_EN
  logic ovf_d;

  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  assign ovf_d = g_stage[LAST].co ^ (g_stage[LAST].s[W-1] ^
                 g_stage[LAST].ua[W-1] ^ g_stage[LAST].ub[W-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (adv) begin
      ovf <= ovf_d;
    end
  end
`endif

endmodule
`default_nettype wire
